// File: rtl/multiexp_fp2_feeder_if.sv
// Valid/ready stream carrying 7-beat point/scalar packets with sop/eop framing.
// Combinational bundle only; the source holds dat/sop/eop/ctl while val & ~rdy.
interface if_axi_stream #(
   parameter int DAT_BITS = 381,
   parameter int CTL_BITS = 16
);
   logic                val;
   logic                rdy;
   logic [DAT_BITS-1:0] dat;
   logic                sop;
   logic                eop;
   logic [CTL_BITS-1:0] ctl;

   modport master (output val, dat, sop, eop, ctl, input rdy);
   modport slave  (input val, dat, sop, eop, ctl, output rdy);
endinterface

// File: rtl/multiexp_fp2_feeder.sv
// Replays a RAM list of scalar/G2 pairs into a multiexp core as 7-beat packets, one entry prefetched.
// First sop RAM_LAT+2 cycles after start; packets back-to-back under rdy, reads stall while prefetch is full.
module multiexp_fp2_feeder #(
   parameter int DAT_BITS  = 381,
   parameter int CTL_BITS  = 16,
   parameter int KEY_BITS  = 256,
   parameter int ADDR_BITS = 10,
   parameter int RAM_LAT   = 2
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_start,
   input  logic [ADDR_BITS:0]     i_num_in,
   input  logic [CTL_BITS-1:0]    i_ctl,
   output logic                   o_rd_en,
   output logic [ADDR_BITS-1:0]   o_rd_addr,
   input  logic [7*DAT_BITS-1:0]  i_rd_dat,
   if_axi_stream.master           o_pnt_scl_if,
   output logic                   o_busy,
   output logic                   o_done
);
   localparam int PASS_W = $clog2(KEY_BITS + 1);
   localparam int CNT_W  = ADDR_BITS + 1 + PASS_W;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                 state, state_nxt;
   logic [ADDR_BITS:0]     num;
   logic [CTL_BITS-1:0]    ctl;
   logic [7*DAT_BITS-1:0]  cur, pre;
   logic                   cur_v, pre_v;
   logic [2:0]             beat;
   logic [ADDR_BITS-1:0]   rd_idx;
   logic [PASS_W-1:0]      rd_pass;
   logic [CNT_W-1:0]       rd_left, tx_left, job_len;
   logic [RAM_LAT-1:0]     rd_pipe;
   logic                   rd_ret, tx_hs, eop_hs, rd_wrap;

   assign rd_ret  = rd_pipe[RAM_LAT-1];
   assign tx_hs   = cur_v & o_pnt_scl_if.rdy;
   assign eop_hs  = tx_hs && (beat == 3'd6);
   assign rd_wrap = ({1'b0, rd_idx} == (num - (ADDR_BITS+1)'(1)));
   assign job_len = CNT_W'(i_num_in) * (i_ctl[0] ? CNT_W'(1) : CNT_W'(KEY_BITS));

   assign o_rd_addr         = rd_idx;
   assign o_busy            = (state == RUN);
   assign o_done            = (state == DONE);
   assign o_pnt_scl_if.val  = cur_v;
   assign o_pnt_scl_if.dat  = cur[beat*DAT_BITS +: DAT_BITS];
   assign o_pnt_scl_if.sop  = cur_v && (beat == 3'd0);
   assign o_pnt_scl_if.eop  = cur_v && (beat == 3'd6);
   assign o_pnt_scl_if.ctl  = ctl;

   always_comb begin
      state_nxt = state;
      o_rd_en   = 1'b0;
      case (state)
         IDLE: if (i_start) state_nxt = (i_num_in == '0) ? DONE : RUN;
         RUN: begin
            // One read in flight at a time; the free slot is cur if empty, else pre.
            o_rd_en = (rd_left != '0) && (rd_pipe == '0) && (!cur_v || !pre_v);
            if (eop_hs && tx_left == CNT_W'(1)) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state   <= IDLE;
         num     <= '0;
         ctl     <= '0;
         cur     <= '0;
         pre     <= '0;
         cur_v   <= 1'b0;
         pre_v   <= 1'b0;
         beat    <= '0;
         rd_idx  <= '0;
         rd_pass <= '0;
         rd_left <= '0;
         tx_left <= '0;
         rd_pipe <= '0;
      end else begin
         state      <= state_nxt;
         rd_pipe[0] <= o_rd_en;
         for (int i = 1; i < RAM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];

         if (state == IDLE && i_start) begin
            num     <= i_num_in;
            ctl     <= i_ctl;
            rd_left <= job_len;
            tx_left <= job_len;
            rd_idx  <= '0;
            rd_pass <= '0;
            beat    <= '0;
            cur_v   <= 1'b0;
            pre_v   <= 1'b0;
         end

         if (o_rd_en) begin
            rd_left <= rd_left - CNT_W'(1);
            if (rd_wrap) begin
               rd_idx  <= '0;
               rd_pass <= rd_pass + PASS_W'(1);
            end else begin
               rd_idx  <= rd_idx + ADDR_BITS'(1);
            end
         end

         if (tx_hs && !eop_hs) beat <= beat + 3'd1;

         if (eop_hs) begin
            tx_left <= tx_left - CNT_W'(1);
            beat    <= '0;
            if (pre_v) begin
               cur   <= pre;
               pre_v <= rd_ret;
               if (rd_ret) pre <= i_rd_dat;
            end else if (rd_ret) begin
               cur <= i_rd_dat;
            end else begin
               cur_v <= 1'b0;
            end
         end else if (rd_ret) begin
            if (!cur_v) begin
               cur   <= i_rd_dat;
               cur_v <= 1'b1;
            end else begin
               pre   <= i_rd_dat;
               pre_v <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_multiexp_fp2_feeder.sv
// Scoreboard bench: expected beats/addresses queued at job start, compared as the DUT emits them.
module tb_multiexp_fp2_feeder;
   localparam int DW = 16, CW = 8, KB = 3, AB = 4, RL = 2;

   typedef struct { logic [DW-1:0] dat; logic sop; logic eop; } beat_t;
   typedef struct { int num; int ctl; int mode; bit poke; int exp_beats; bit timing; } vec_t;

   logic clk = 1'b0, rst = 1'b1, start = 1'b0, rdy = 1'b1;
   logic [AB:0] num_in = '0;
   logic [CW-1:0] ctl_in = '0;
   logic rd_en, busy, done;
   logic [AB-1:0] rd_addr;
   logic [7*DW-1:0] rd_dat;

   if_axi_stream #(.DAT_BITS(DW), .CTL_BITS(CW)) bus ();
   assign bus.rdy = rdy;

   multiexp_fp2_feeder #(.DAT_BITS(DW), .CTL_BITS(CW), .KEY_BITS(KB), .ADDR_BITS(AB), .RAM_LAT(RL)) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_num_in(num_in), .i_ctl(ctl_in),
      .o_rd_en(rd_en), .o_rd_addr(rd_addr), .i_rd_dat(rd_dat),
      .o_pnt_scl_if(bus), .o_busy(busy), .o_done(done));

   always #5 clk = ~clk;

   logic [7*DW-1:0] mem [16];
   logic [AB-1:0] ap [RL];
   always @(posedge clk) begin
      ap[0] <= rd_addr;
      for (int i = 1; i < RL; i++) ap[i] <= ap[i-1];
   end
   assign rd_dat = mem[ap[RL-1]];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int rdy_mode = 0;
   always @(posedge clk) begin
      #1;
      if (rdy_mode == 1) rdy = 1'($urandom_range(0, 1));
      else rdy = 1'b1;
   end

   int checks = 0, errors = 0;
   int beats, first_val, last_hs, done_cyc, rd_cnt;
   bit mon_on = 1'b0, held = 1'b0;
   logic [DW-1:0] h_dat;
   logic h_sop, h_eop;
   logic [CW-1:0] exp_ctl;
   beat_t exp_q[$];
   logic [AB-1:0] addr_q[$];

   function automatic logic [DW-1:0] word(input int a, input int w);
      return DW'(32'hA000 + a * 16 + w);
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   beat_t e;
   always @(negedge clk) begin
      if (mon_on) begin
         if (rd_en) begin
            rd_cnt++;
            if (addr_q.size() == 0) chk("rd_extra", 1, 0);
            else chk("rd_addr", rd_addr, addr_q.pop_front());
         end
         if (bus.val) begin
            if (first_val < 0) first_val = cyc;
            if (held) begin
               chk("hold_dat", bus.dat, h_dat);
               chk("hold_sop", bus.sop, h_sop);
               chk("hold_eop", bus.eop, h_eop);
            end
            if (rdy) begin
               if (exp_q.size() == 0) chk("beat_extra", 1, 0);
               else begin
                  e = exp_q.pop_front();
                  chk("dat", bus.dat, e.dat);
                  chk("sop", bus.sop, e.sop);
                  chk("eop", bus.eop, e.eop);
                  chk("ctl", bus.ctl, exp_ctl);
               end
               beats++;
               last_hs = cyc;
               held = 1'b0;
            end else begin
               held = 1'b1;
               h_dat = bus.dat; h_sop = bus.sop; h_eop = bus.eop;
            end
         end else if (held) begin
            chk("val_dropped_unaccepted", 0, 1);
            held = 1'b0;
         end
         if (done && done_cyc < 0) begin
            done_cyc = cyc;
            chk("busy_at_done", busy, 0);
         end
      end
   end

   task automatic launch(input int num, input int ctl, input int mode, output int s);
      int passes;
      passes = (ctl % 2 == 1) ? 1 : KB;
      exp_q.delete();
      addr_q.delete();
      for (int p = 0; p < passes; p++)
         for (int a = 0; a < num; a++) begin
            addr_q.push_back(AB'(a));
            for (int w = 0; w < 7; w++) exp_q.push_back('{word(a, w), (w == 0), (w == 6)});
         end
      exp_ctl = CW'(ctl);
      beats = 0; first_val = -1; last_hs = -1; done_cyc = -1; rd_cnt = 0; held = 1'b0;
      rdy_mode = mode;
      mon_on = 1'b1;
      @(posedge clk); #1;
      start = 1'b1; num_in = (AB+1)'(num); ctl_in = CW'(ctl);
      @(negedge clk); s = cyc;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic finish_job(input int exp_beats, input bit timing, input int s);
      int n;
      n = 0;
      while (done_cyc < 0 && n < 3000) begin @(posedge clk); n++; end
      if (done_cyc < 0) chk("done_timeout", 0, 1);
      chk("beat_count", beats, exp_beats);
      chk("exp_left", exp_q.size(), 0);
      chk("addr_left", addr_q.size(), 0);
      chk("rd_count", rd_cnt, exp_beats / 7);
      chk("done_after_last_eop", done_cyc, last_hs + 1);
      if (timing) begin
         chk("first_val_latency", first_val - s, 2 + RL);
         chk("no_gaps", last_hs - first_val, exp_beats - 1);
      end
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      mon_on = 1'b0;
      rdy_mode = 0;
   endtask

   vec_t vecs[6];

   initial begin
      int s, n;
      vecs[0] = '{4, 1, 0, 1'b0, 28, 1'b1};
      vecs[1] = '{2, 0, 0, 1'b0, 42, 1'b1};
      vecs[2] = '{4, 1, 1, 1'b0, 28, 1'b0};
      vecs[3] = '{1, 0, 0, 1'b0, 21, 1'b1};
      vecs[4] = '{3, 0, 1, 1'b0, 63, 1'b0};
      vecs[5] = '{3, 1, 0, 1'b1, 21, 1'b1};
      for (int a = 0; a < 16; a++)
         for (int w = 0; w < 7; w++) mem[a][w*DW +: DW] = word(a, w);

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_val", bus.val, 0);
      chk("rst_sop", bus.sop, 0);
      chk("rst_eop", bus.eop, 0);
      chk("rst_dat", bus.dat, 0);
      chk("rst_ctl", bus.ctl, 0);
      chk("rst_rd_en", rd_en, 0);
      chk("rst_rd_addr", rd_addr, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      for (int v = 0; v < 6; v++) begin
         launch(vecs[v].num, vecs[v].ctl, vecs[v].mode, s);
         if (vecs[v].poke) begin
            repeat (8) @(posedge clk);
            #1; start = 1'b1; num_in = 5'd2; ctl_in = '0;
            @(posedge clk); #1; start = 1'b0;
         end
         finish_job(vecs[v].exp_beats, vecs[v].timing, s);
      end

      // Zero-length job
      launch(0, 1, 0, s);
      repeat (6) @(posedge clk);
      chk("zero_done_cycle", done_cyc - s, 1);
      chk("zero_no_reads", rd_cnt, 0);
      chk("zero_no_beats", beats, 0);
      mon_on = 1'b0;

      // Reset during beat 3 of packet 2, then a fresh job
      launch(4, 1, 0, s);
      n = 0;
      while (beats < 10 && n < 500) begin @(posedge clk); n++; end
      chk("reach_pkt2_beat3", beats, 10);
      #1; rst = 1'b1; mon_on = 1'b0;
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      chk("rst_mid_val", bus.val, 0);
      chk("rst_mid_busy", busy, 0);
      repeat (4) @(posedge clk);
      launch(2, 1, 0, s);
      finish_job(14, 1'b1, s);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
